// File: rtl/load_pkg.sv
// Shared encodings, FSM state type and size helper for the load align unit.
package load_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1,
    ST_DONE
  } ld_state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'(1) << size;
  endfunction

endpackage

// File: rtl/load_align_unit_extract.sv
// Combinational right-align and sign/zero-extend of a one- or two-beat window.
module load_extract
  import load_pkg::*;
#(
  parameter  int unsigned XLEN  = 32,
  localparam int unsigned OFS_W = $clog2(XLEN / 8)
) (
  input  logic [2*XLEN-1:0] beats_i,
  input  logic [OFS_W-1:0]  ofs_i,
  input  logic [1:0]        size_i,
  input  logic              uns_i,
  output logic [XLEN-1:0]   result_c
);

  logic [XLEN-1:0] low;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] top;
  logic [6:0]      nbits;

  // Full-width loads give an all-ones mask because the shift overflows to zero.
  always_comb begin
    nbits    = {size_bytes(size_i), 3'b000};
    low      = XLEN'(beats_i >> {ofs_i, 3'b000});
    mask     = (XLEN'(1) << nbits) - XLEN'(1);
    top      = mask & ~(mask >> 1);
    result_c = (low & mask) | ((!uns_i && (|(low & top))) ? ~mask : '0);
  end

endmodule

// File: rtl/load_align_unit.sv
// Load request sequencer: issues one or two aligned beats and returns the formatted result.
module load_align_unit
  import load_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter bit          MISALIGN_EN = 1'b1
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              req_valid_in,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_in,
  input  logic [1:0]        req_size_in,
  input  logic              req_unsigned_in,
  input  logic [4:0]        req_rd_in,
  output logic              dm_req_valid_o,
  input  logic              dm_req_ready_in,
  output logic [ADDR_W-1:0] dm_addr_o,
  input  logic              dm_rsp_valid_in,
  input  logic [XLEN-1:0]   dm_data_in,
  output logic              ld_valid_o,
  input  logic              ld_ready_in,
  output logic [XLEN-1:0]   ld_data_o,
  output logic [4:0]        ld_rd_o,
  output logic              ld_fault_o
);

  localparam int unsigned BYTES = XLEN / 8;
  localparam int unsigned OFS_W = $clog2(BYTES);

  ld_state_t         state_q, state_d;
  logic [OFS_W-1:0]  ofs_q, ofs_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [4:0]        rd_q, rd_d;
  logic              cross_q, cross_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              req_ready_q, req_ready_d;
  logic              dm_req_valid_q, dm_req_valid_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic              ld_valid_q, ld_valid_d;
  logic [XLEN-1:0]   ld_data_q, ld_data_d;
  logic              ld_fault_q, ld_fault_d;

  logic              req_cross;
  logic              req_illegal;
  logic [2*XLEN-1:0] ext_beats;
  logic [XLEN-1:0]   ext_result;

  // Second beat pairs the live response with the held first beat; single beats see hi = 0.
  always_comb begin
    req_cross   = (5'(req_addr_in[OFS_W-1:0]) + 5'(size_bytes(req_size_in))) > 5'(BYTES);
    req_illegal = (req_size_in == SZ_D) && (XLEN == 32);
    ext_beats   = (state_q == ST_WAIT1) ? {dm_data_in, lo_q} : {XLEN'(0), dm_data_in};
  end

  load_extract #(.XLEN(XLEN)) u_extract (
    .beats_i  (ext_beats),
    .ofs_i    (ofs_q),
    .size_i   (size_q),
    .uns_i    (uns_q),
    .result_c (ext_result)
  );

  always_comb begin
    state_d    = state_q;
    ofs_d      = ofs_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rd_d       = rd_q;
    cross_d    = cross_q;
    lo_d       = lo_q;
    dm_addr_d  = dm_addr_q;
    ld_data_d  = ld_data_q;
    ld_fault_d = ld_fault_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_in && req_ready_q) begin
          ofs_d   = req_addr_in[OFS_W-1:0];
          size_d  = req_size_in;
          uns_d   = req_unsigned_in;
          rd_d    = req_rd_in;
          cross_d = req_cross;
          if (req_illegal || (req_cross && !MISALIGN_EN)) begin
            state_d    = ST_DONE;
            ld_fault_d = 1'b1;
            ld_data_d  = '0;
          end else begin
            state_d    = ST_REQ0;
            ld_fault_d = 1'b0;
            dm_addr_d  = {req_addr_in[ADDR_W-1:OFS_W], OFS_W'(0)};
          end
        end
      end
      ST_REQ0: begin
        if (dm_req_ready_in) state_d = ST_WAIT0;
      end
      ST_WAIT0: begin
        if (dm_rsp_valid_in) begin
          lo_d = dm_data_in;
          if (cross_q) begin
            state_d   = ST_REQ1;
            dm_addr_d = dm_addr_q + ADDR_W'(BYTES);
          end else begin
            state_d   = ST_DONE;
            ld_data_d = ext_result;
          end
        end
      end
      ST_REQ1: begin
        if (dm_req_ready_in) state_d = ST_WAIT1;
      end
      ST_WAIT1: begin
        if (dm_rsp_valid_in) begin
          state_d   = ST_DONE;
          ld_data_d = ext_result;
        end
      end
      ST_DONE: begin
        if (ld_ready_in) begin
          state_d    = ST_IDLE;
          ld_fault_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d    = (state_d == ST_IDLE);
    dm_req_valid_d = (state_d == ST_REQ0) || (state_d == ST_REQ1);
    ld_valid_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q        <= ST_IDLE;
      ofs_q          <= '0;
      size_q         <= '0;
      uns_q          <= 1'b0;
      rd_q           <= '0;
      cross_q        <= 1'b0;
      lo_q           <= '0;
      req_ready_q    <= 1'b1;
      dm_req_valid_q <= 1'b0;
      dm_addr_q      <= '0;
      ld_valid_q     <= 1'b0;
      ld_data_q      <= '0;
      ld_fault_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      ofs_q          <= ofs_d;
      size_q         <= size_d;
      uns_q          <= uns_d;
      rd_q           <= rd_d;
      cross_q        <= cross_d;
      lo_q           <= lo_d;
      req_ready_q    <= req_ready_d;
      dm_req_valid_q <= dm_req_valid_d;
      dm_addr_q      <= dm_addr_d;
      ld_valid_q     <= ld_valid_d;
      ld_data_q      <= ld_data_d;
      ld_fault_q     <= ld_fault_d;
    end
  end

  assign req_ready_o    = req_ready_q;
  assign dm_req_valid_o = dm_req_valid_q;
  assign dm_addr_o      = dm_addr_q;
  assign ld_valid_o     = ld_valid_q;
  assign ld_data_o      = ld_data_q;
  assign ld_rd_o        = rd_q;
  assign ld_fault_o     = ld_fault_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: directed plan cases plus randomized loads against a byte-level model.
module tb_load_align_unit;

  logic clk = 1'b0;
  logic reset_in;
  always #5 clk = ~clk;

  // Main DUT: XLEN=32, split loads enabled
  logic        req_valid, req_ready, req_uns, dm_req_valid, dm_req_ready, dm_rsp_valid;
  logic        ld_valid, ld_ready, ld_fault;
  logic [31:0] req_addr, dm_addr, dm_data, ld_data;
  logic [1:0]  req_size;
  logic [4:0]  req_rd, ld_rd;

  load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b1)) dut (
    .clk_in(clk), .reset_in(reset_in),
    .req_valid_in(req_valid), .req_ready_o(req_ready), .req_addr_in(req_addr),
    .req_size_in(req_size), .req_unsigned_in(req_uns), .req_rd_in(req_rd),
    .dm_req_valid_o(dm_req_valid), .dm_req_ready_in(dm_req_ready), .dm_addr_o(dm_addr),
    .dm_rsp_valid_in(dm_rsp_valid), .dm_data_in(dm_data),
    .ld_valid_o(ld_valid), .ld_ready_in(ld_ready), .ld_data_o(ld_data),
    .ld_rd_o(ld_rd), .ld_fault_o(ld_fault));

  // No-split DUT: boundary crossings fault
  logic        nm_req_valid, nm_req_ready, nm_dm_req_valid, nm_ld_valid, nm_ld_ready, nm_ld_fault;
  logic [31:0] nm_dm_addr, nm_ld_data;
  logic [4:0]  nm_ld_rd;
  logic [1:0]  nm_size;
  logic [31:0] nm_addr;
  logic        nm_seen;

  load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b0)) dut_nm (
    .clk_in(clk), .reset_in(reset_in),
    .req_valid_in(nm_req_valid), .req_ready_o(nm_req_ready), .req_addr_in(nm_addr),
    .req_size_in(nm_size), .req_unsigned_in(1'b0), .req_rd_in(5'd3),
    .dm_req_valid_o(nm_dm_req_valid), .dm_req_ready_in(1'b1), .dm_addr_o(nm_dm_addr),
    .dm_rsp_valid_in(1'b0), .dm_data_in(32'h0),
    .ld_valid_o(nm_ld_valid), .ld_ready_in(nm_ld_ready), .ld_data_o(nm_ld_data),
    .ld_rd_o(nm_ld_rd), .ld_fault_o(nm_ld_fault));

  // 64-bit DUT
  logic        w_req_valid, w_req_ready, w_uns, w_dm_req_valid, w_dm_ready, w_rsp_valid;
  logic        w_ld_valid, w_ld_ready, w_ld_fault;
  logic [31:0] w_addr, w_dm_addr;
  logic [1:0]  w_size;
  logic [63:0] w_dm_data, w_ld_data;
  logic [4:0]  w_ld_rd;

  load_align_unit #(.XLEN(64), .ADDR_W(32), .MISALIGN_EN(1'b1)) dut_w (
    .clk_in(clk), .reset_in(reset_in),
    .req_valid_in(w_req_valid), .req_ready_o(w_req_ready), .req_addr_in(w_addr),
    .req_size_in(w_size), .req_unsigned_in(w_uns), .req_rd_in(5'd9),
    .dm_req_valid_o(w_dm_req_valid), .dm_req_ready_in(w_dm_ready), .dm_addr_o(w_dm_addr),
    .dm_rsp_valid_in(w_rsp_valid), .dm_data_in(w_dm_data),
    .ld_valid_o(w_ld_valid), .ld_ready_in(w_ld_ready), .ld_data_o(w_ld_data),
    .ld_rd_o(w_ld_rd), .ld_fault_o(w_ld_fault));

  int n_cmp = 0;
  int n_err = 0;

  // Memory image: explicit words override a hashed background pattern
  logic [31:0] ovr [logic [31:0]];
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return (a * 32'h9E3779B1) ^ 32'hA5A51234;
  endfunction

  // Zero-wait memory for the main DUT: data arrives the cycle after the request handshake
  logic        hs_n = 1'b0;
  logic [31:0] hs_addr = 32'h0;
  int          dm_cnt = 0;
  logic [31:0] addr_log [$];
  always @(negedge clk) begin
    hs_n    = dm_req_valid && dm_req_ready;
    hs_addr = dm_addr;
  end
  always @(posedge clk) begin
    #1;
    dm_rsp_valid = hs_n;
    if (hs_n) begin
      dm_data = mem_word(hs_addr);
      dm_cnt++;
      addr_log.push_back(hs_addr);
    end
  end

  always @(negedge clk) if (nm_dm_req_valid) nm_seen = 1'b1;

  // Reference: gather bytes one at a time from the byte-addressed image, then extend
  function automatic void ref_load(input logic [31:0] a, input logic [1:0] s, input logic u,
                                   output logic [31:0] d, output logic f, output int lat,
                                   output int beats);
    int nb;
    logic [31:0] v, ba, w;
    if (s == 2'b11) begin
      d = 32'h0; f = 1'b1; lat = 1; beats = 0;
      return;
    end
    nb = 1 << s;
    v  = 32'h0;
    for (int i = 0; i < nb; i++) begin
      ba = a + 32'(i);
      w  = mem_word({ba[31:2], 2'b00});
      v  = v | (((w >> (8 * ba[1:0])) & 32'hFF) << (8 * i));
    end
    if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8 * nb));
    d     = v;
    f     = 1'b0;
    beats = (int'(a[1:0]) + nb > 4) ? 2 : 1;
    lat   = (beats == 2) ? 5 : 3;
  endfunction

  task automatic do_load(input logic [31:0] a, input logic [1:0] s, input logic u,
                         input logic [4:0] rd, output logic [31:0] d, output logic f,
                         output logic [4:0] r, output int lat, output int beats);
    int c0, n;
    n = 0;
    @(posedge clk); #1;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    c0 = dm_cnt;
    req_valid = 1'b1; req_addr = a; req_size = s; req_uns = u; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!ld_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    d = ld_data; f = ld_fault; r = ld_rd;
    ld_ready = 1'b1;
    @(posedge clk); #1;
    ld_ready = 1'b0;
    beats = dm_cnt - c0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_cmp++; if ({dm_req_valid, ld_valid, ld_fault} !== 3'b000) begin n_err++; $display("FAIL reset_valids got %b want 000", {dm_req_valid, ld_valid, ld_fault}); end
    n_cmp++; if ({ld_data, ld_rd, dm_addr} !== 69'h0) begin n_err++; $display("FAIL reset_data got %h/%h/%h want 0", ld_data, ld_rd, dm_addr); end
    n_cmp++; if ({nm_req_ready, w_req_ready} !== 2'b11) begin n_err++; $display("FAIL reset_other_ready got %b want 11", {nm_req_ready, w_req_ready}); end
    reset_in = 1'b0;
  endtask

  task automatic test_byte_half();
    logic [31:0] d; logic f; logic [4:0] r; int lat, beats;
    ovr[32'h1000] = 32'h80FFFFFF;
    do_load(32'h1003, 2'b00, 1'b0, 5'd17, d, f, r, lat, beats);
    n_cmp++; if (d !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_data got %h want ffffff80", d); end
    n_cmp++; if (lat != 3 || beats != 1) begin n_err++; $display("FAIL lb_timing got lat=%0d beats=%0d want 3/1", lat, beats); end
    n_cmp++; if (r !== 5'd17 || f !== 1'b0) begin n_err++; $display("FAIL lb_rd_fault got %0d/%b want 17/0", r, f); end
    ovr[32'h1000] = 32'hBEEF1234;
    do_load(32'h1002, 2'b01, 1'b1, 5'd4, d, f, r, lat, beats);
    n_cmp++; if (d !== 32'h0000BEEF) begin n_err++; $display("FAIL lhu_data got %h want 0000beef", d); end
    do_load(32'h1002, 2'b01, 1'b0, 5'd4, d, f, r, lat, beats);
    n_cmp++; if (d !== 32'hFFFFBEEF) begin n_err++; $display("FAIL lh_data got %h want ffffbeef", d); end
  endtask

  task automatic test_split();
    logic [31:0] d, ed; logic f, ef; logic [4:0] r; int lat, beats, el, eb;
    ovr[32'h1004] = 32'hDDCCBBAA;
    ovr[32'h1008] = 32'h44332211;
    addr_log.delete();
    do_load(32'h1006, 2'b10, 1'b0, 5'd5, d, f, r, lat, beats);
    n_cmp++; if (d !== 32'h2211DDCC) begin n_err++; $display("FAIL split_data got %h want 2211ddcc", d); end
    n_cmp++; if (lat != 5 || beats != 2) begin n_err++; $display("FAIL split_timing got lat=%0d beats=%0d want 5/2", lat, beats); end
    n_cmp++; if (addr_log.size() != 2 || addr_log[0] !== 32'h1004 || addr_log[1] !== 32'h1008) begin
      n_err++; $display("FAIL split_addrs got n=%0d want 1004,1008", addr_log.size()); end
    addr_log.delete();
    do_load(32'hFFFFFFFE, 2'b10, 1'b1, 5'd6, d, f, r, lat, beats);
    ref_load(32'hFFFFFFFE, 2'b10, 1'b1, ed, ef, el, eb);
    n_cmp++; if (d !== ed) begin n_err++; $display("FAIL wrap_data got %h want %h", d, ed); end
    n_cmp++; if (addr_log.size() != 2 || addr_log[0] !== 32'hFFFFFFFC || addr_log[1] !== 32'h0) begin
      n_err++; $display("FAIL wrap_addrs got n=%0d want fffffffc,00000000", addr_log.size()); end
  endtask

  task automatic test_illegal_size();
    logic [31:0] d; logic f; logic [4:0] r; int lat, beats;
    do_load(32'h1000, 2'b11, 1'b0, 5'd8, d, f, r, lat, beats);
    n_cmp++; if (f !== 1'b1 || d !== 32'h0) begin n_err++; $display("FAIL size11 got fault=%b data=%h want 1/0", f, d); end
    n_cmp++; if (lat != 1 || beats != 0) begin n_err++; $display("FAIL size11_timing got lat=%0d beats=%0d want 1/0", lat, beats); end
  endtask

  task automatic test_no_misalign();
    int lat;
    nm_seen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      nm_req_valid = 1'b1;
      nm_addr = (k == 0) ? 32'h1006 : 32'h1000;
      nm_size = (k == 0) ? 2'b10 : 2'b11;
      @(posedge clk); #1;
      nm_req_valid = 1'b0;
      lat = 1;
      while (!nm_ld_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      n_cmp++; if (nm_ld_fault !== 1'b1 || nm_ld_data !== 32'h0 || lat != 1) begin
        n_err++; $display("FAIL nomis_fault%0d got fault=%b data=%h lat=%0d want 1/0/1", k, nm_ld_fault, nm_ld_data, lat); end
      nm_ld_ready = 1'b1;
      @(posedge clk); #1;
      nm_ld_ready = 1'b0;
    end
    n_cmp++; if (nm_seen !== 1'b0) begin n_err++; $display("FAIL nomis_dmreq got %b want 0", nm_seen); end
  endtask

  task automatic test_backpressure();
    logic [31:0] ed; logic ef; int el, eb, n;
    ref_load(32'h1000, 2'b10, 1'b0, ed, ef, el, eb);
    dm_req_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h1000; req_size = 2'b10; req_uns = 1'b0; req_rd = 5'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (dm_req_valid !== 1'b1 || dm_addr !== 32'h1000) begin
        n_err++; $display("FAIL dm_stall%0d got v=%b addr=%h want 1/1000", i, dm_req_valid, dm_addr); end
      @(posedge clk); #1;
    end
    dm_req_ready = 1'b1;
    n = 0;
    while (!ld_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ld_valid !== 1'b1 || ld_data !== ed || ld_rd !== 5'd7 || req_ready !== 1'b0) begin
        n_err++; $display("FAIL ld_stall%0d got v=%b d=%h rd=%0d rdy=%b want 1/%h/7/0", i, ld_valid, ld_data, ld_rd, req_ready, ed); end
      @(posedge clk); #1;
    end
    ld_ready = 1'b1;
    @(posedge clk); #1;
    ld_ready = 1'b0;
    n_cmp++; if (req_ready !== 1'b1 || ld_valid !== 1'b0) begin n_err++; $display("FAIL ld_release got rdy=%b v=%b want 1/0", req_ready, ld_valid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, ed; logic f, ef; logic [4:0] r; int lat, beats, el, eb;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h1006; req_size = 2'b10; req_uns = 1'b0; req_rd = 5'd21;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset_in = 1'b1;
    @(posedge clk); #1;
    reset_in = 1'b0;
    n_cmp++; if (req_ready !== 1'b1 || {dm_req_valid, ld_valid, ld_fault} !== 3'b000) begin
      n_err++; $display("FAIL midreset_ctl got rdy=%b v=%b want 1/000", req_ready, {dm_req_valid, ld_valid, ld_fault}); end
    n_cmp++; if ({ld_data, ld_rd, dm_addr} !== 69'h0) begin n_err++; $display("FAIL midreset_data got %h/%h/%h want 0", ld_data, ld_rd, dm_addr); end
    do_load(32'h1001, 2'b00, 1'b1, 5'd2, d, f, r, lat, beats);
    ref_load(32'h1001, 2'b00, 1'b1, ed, ef, el, eb);
    n_cmp++; if (d !== ed || lat != 3) begin n_err++; $display("FAIL post_reset got %h lat=%0d want %h/3", d, lat, ed); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, ed; logic [1:0] s; logic u, f, ef; logic [4:0] rd, r; int lat, beats, el, eb;
    for (int i = 0; i < 60; i++) begin
      a  = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF8 | 32'($urandom_range(0, 7))) : $urandom;
      s  = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      rd = 5'($urandom_range(0, 31));
      do_load(a, s, u, rd, d, f, r, lat, beats);
      ref_load(a, s, u, ed, ef, el, eb);
      n_cmp++; if (d !== ed || f !== ef) begin n_err++; $display("FAIL rand%0d_data a=%h s=%0d u=%b got %h/%b want %h/%b", i, a, s, u, d, f, ed, ef); end
      n_cmp++; if (r !== rd) begin n_err++; $display("FAIL rand%0d_rd got %0d want %0d", i, r, rd); end
      n_cmp++; if (lat != el || beats != eb) begin n_err++; $display("FAIL rand%0d_timing got %0d/%0d want %0d/%0d", i, lat, beats, el, eb); end
    end
  endtask

  task automatic test_xlen64();
    logic [31:0] a, dma; logic [1:0] s; logic [63:0] beat, exp; logic hs; int lat;
    for (int k = 0; k < 2; k++) begin
      a    = (k == 0) ? 32'h2000 : 32'h2004;
      s    = (k == 0) ? 2'b11 : 2'b10;
      beat = (k == 0) ? 64'h8000000000000001 : 64'h8000000012345678;
      exp  = (k == 0) ? 64'h8000000000000001 : 64'hFFFFFFFF80000000;
      beat = (k == 1) ? 64'h12345678_80000000 ^ 64'h0 : beat;
      exp  = (k == 1) ? 64'h0000000012345678 : exp;
      w_uns = (k == 1);
      hs = 1'b0; dma = 32'hX;
      @(posedge clk); #1;
      w_req_valid = 1'b1; w_addr = a; w_size = s;
      @(posedge clk); #1;
      w_req_valid = 1'b0;
      lat = 1;
      while (!w_ld_valid && lat < 40) begin
        hs = w_dm_req_valid && w_dm_ready;
        if (hs) dma = w_dm_addr;
        @(posedge clk); #1;
        lat++;
        w_rsp_valid = hs;
        w_dm_data   = beat;
      end
      w_rsp_valid = 1'b0;
      n_cmp++; if (w_ld_data !== exp || w_ld_fault !== 1'b0) begin n_err++; $display("FAIL x64_%0d_data got %h/%b want %h/0", k, w_ld_data, w_ld_fault, exp); end
      n_cmp++; if (dma !== 32'h2000 || lat != 3) begin n_err++; $display("FAIL x64_%0d_addr got %h lat=%0d want 2000/3", k, dma, lat); end
      w_ld_ready = 1'b1;
      @(posedge clk); #1;
      w_ld_ready = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset_in = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_size = '0; req_uns = 1'b0; req_rd = '0;
    dm_req_ready = 1'b1; dm_rsp_valid = 1'b0; dm_data = '0; ld_ready = 1'b0;
    nm_req_valid = 1'b0; nm_addr = '0; nm_size = '0; nm_ld_ready = 1'b0; nm_seen = 1'b0;
    w_req_valid = 1'b0; w_addr = '0; w_size = '0; w_uns = 1'b0; w_dm_ready = 1'b1;
    w_rsp_valid = 1'b0; w_dm_data = '0; w_ld_ready = 1'b0;
    test_reset();
    test_byte_half();
    test_split();
    test_illegal_size();
    test_no_misalign();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_xlen64();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Parametrised successor to the combinational load data formatter.
- Accepts one load request at a time and issues one or two aligned data-memory beats over a valid/ready handshake.
- Right-aligns and sign- or zero-extends the selected bytes, including loads that cross a beat boundary.
- Sits between the execute-stage address adder and writeback. Returns the result with its destination register tag under valid/ready.

Parameters:
- XLEN, 32, data/beat width in bits; legal values 32 or 64. BYTES = XLEN/8, OFS_W = log2(BYTES).
- ADDR_W, 32, byte-address width.
- MISALIGN_EN, 1, 1 = split boundary-crossing loads into two beats; 0 = flag them as misaligned faults.

Ports:
- clk_in  input  1  single clock; all state on rising edge.
- reset_in  input  1  synchronous, active-high reset.
- req_valid_in  input  1  load request valid.
- req_ready_o  output  1  unit can accept a request.
- req_addr_in  input  ADDR_W  byte address.
- req_size_in  input  2  00 byte, 01 half, 10 word, 11 double (XLEN=64 only).
- req_unsigned_in  input  1  1 = zero-extend, 0 = sign-extend.
- req_rd_in  input  5  destination register tag.
- dm_req_valid_o  output  1  memory read request valid.
- dm_req_ready_in  input  1  memory accepts request.
- dm_addr_o  output  ADDR_W  beat address, low OFS_W bits always 0.
- dm_rsp_valid_in  input  1  read data valid.
- dm_data_in  input  XLEN  read data, little-endian lanes.
- ld_valid_o  output  1  result valid.
- ld_ready_in  input  1  consumer accepts result.
- ld_data_o  output  XLEN  extended load result.
- ld_rd_o  output  5  captured req_rd_in.
- ld_fault_o  output  1  misaligned or illegal-size fault, qualified by ld_valid_o.

Behaviour:
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
- Reset: state goes to IDLE. req_ready_o=1 after reset. dm_req_valid_o, ld_valid_o and ld_fault_o are 0. ld_data_o, ld_rd_o and dm_addr_o are 0.
- req_ready_o=1 only in IDLE. A request is accepted on req_valid_in&req_ready_o, and addr, size, unsigned and rd are registered at that point.
- Request classification: nbytes = 1<<size; ofs = addr[OFS_W-1:0]; cross = ofs+nbytes > BYTES.
- Illegal requests: size=11 with XLEN=32 is illegal. An illegal request, or cross with MISALIGN_EN=0, goes IDLE->DONE with ld_fault_o=1, ld_data_o=0 and no memory request.
- Legal requests go IDLE->REQ0.
- REQ0: dm_req_valid_o=1, dm_addr_o = addr with low OFS_W bits cleared. Moves to WAIT0 on dm_req_ready_in. Address and valid are held stable while ready is low.
- WAIT0: capture dm_data_in into lo on dm_rsp_valid_in. Go to REQ1 if cross, else DONE.
- REQ1: dm_addr_o = aligned addr + BYTES, wrapping modulo 2^ADDR_W. Moves to WAIT1 on dm_req_ready_in.
- WAIT1: capture dm_data_in into hi on dm_rsp_valid_in, then go to DONE.
- dm_rsp_valid_in is ignored outside WAIT0/WAIT1.
- Extraction: form the 2*XLEN vector {hi,lo}, with hi=0 for a single beat. Shift right by ofs*8, keep the low nbytes*8 bits, then sign- or zero-extend to XLEN. When nbytes=BYTES the value is passed through.
- DONE: ld_valid_o=1. ld_data_o, ld_rd_o and ld_fault_o are registered and held stable until ld_valid_o&ld_ready_in, then the unit returns to IDLE. No new request is accepted in the same cycle.
- Latency from acceptance to ld_valid_o, with zero-wait memory (ready high, response one cycle after request): 3 cycles for a single beat, 5 for a split load, 1 for a fault.
- reset_in mid-operation: abort immediately, return to IDLE with reset values. Any outstanding memory response is dropped; the memory side is reset by the same reset_in.

Decomposition:
- Shared package load_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - state enum ld_state_t;
  - function size_bytes(size).
- One natural sub-module, load_extract: purely combinational. Inputs are {hi,lo}, ofs, size and unsigned; output is the extended XLEN result. The parent module holds the FSM and registers.

Test Plan:
- XLEN=32, LB at 0x1003, beat 0x1000 returns 0x80FFFFFF -> ld_data_o=0xFFFFFF80, one dm request, valid 3 cycles after acceptance.
- LHU at 0x1002, returns 0xBEEF1234 -> 0x0000BEEF. LH at the same address -> 0xFFFFBEEF.
- MISALIGN_EN=1, LW at 0x1006: beat 0x1004 returns 0xDDCCBBAA, beat 0x1008 returns 0x44332211 -> 0x2211DDCC, exactly two dm requests, valid 5 cycles after acceptance. LW at 0xFFFFFFFE -> second beat at 0x00000000.
- MISALIGN_EN=0, same LW at 0x1006 -> ld_fault_o=1, ld_data_o=0, dm_req_valid_o never asserted. Size 11 with XLEN=32 -> fault.
- Backpressure: dm_req_ready_in held low 4 cycles -> dm_addr_o stable. ld_ready_in held low 3 cycles -> outputs stable and req_ready_o=0 throughout.
- reset_in asserted in WAIT1 -> next cycle IDLE with all outputs 0. XLEN=64 LD at 0x2000 returning 0x8000000000000001 -> same value passed through unchanged.
